spi_word_fifo: RTL and testbench

//  Synchronous first-word-fall-through (FWFT) word FIFO that implements the SPI command buffer and the SPI read buffer.
//  AXI register logic writes command words into the command instance; the SPI controller pops them via rd_en/empty/dout.
//  The SPI controller pushes received words into the read instance; AXI register logic drains them.

---
 rtl/spi_word_fifo.sv | 127 ++++++++++++
 tb/tb_spi_word_fifo.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_word_fifo.sv
// spi_word_fifo: first-word-fall-through word FIFO used for the SPI command
// and read buffers. Provides occupancy count, almost-full, synchronous flush
// and sticky overflow/underflow flags for software debug.
module spi_word_fifo #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int DEPTH              = 16,
  parameter int ALMOST_FULL_THRESH = DEPTH - 2
) (
  input  logic                          axi_clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          wr_en,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] din,
  output logic                          full,
  output logic                          almost_full,
  input  logic                          rd_en,
  output logic [C_S_AXI_DATA_WIDTH-1:0] dout,
  output logic                          empty,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          overflow,
  output logic                          underflow,
  input  logic                          clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL_THRESH);

  logic [C_S_AXI_DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic empty_s, full_s, almost_full_s;
  logic rd_ok_s, wr_ok_s, mem_we_s;
  logic [C_S_AXI_DATA_WIDTH-1:0] dout_s;

  // Status flags are pure decodes of the registered count; dout is the head word or zero.
  always_comb begin
    empty_s       = (count_q == {CW{1'b0}});
    full_s        = (count_q == DEPTH_C);
    almost_full_s = (count_q >= AF_C);
    if (empty_s) begin
      dout_s = {C_S_AXI_DATA_WIDTH{1'b0}};
    end else begin
      dout_s = mem_q[rd_ptr_q];
    end
  end

  // Accept rules and next-state: clear wins over push/pop; a pop frees room for a push when full.
  always_comb begin
    rd_ok_s     = rd_en & ~empty_s;
    wr_ok_s     = wr_en & (~full_s | rd_ok_s);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    mem_we_s    = 1'b0;
    overflow_d  = overflow_q & ~clr_err;
    underflow_d = underflow_q & ~clr_err;
    if (clear) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (wr_ok_s) begin
        mem_we_s = 1'b1;
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_ok_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CW'(wr_ok_s) - CW'(rd_ok_s);
      // Set has priority over clr_err.
      if (wr_en & ~wr_ok_s) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_d;
      end
      if (rd_en & empty_s) begin
        underflow_d = 1'b1;
      end else begin
        underflow_d = underflow_d;
      end
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge axi_clk) begin
    if (reset) begin
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      count_q     <= {CW{1'b0}};
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Word storage; contents are intentionally not reset.
  always_ff @(posedge axi_clk) begin
    if (mem_we_s && !reset) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign full        = full_s;
  assign almost_full = almost_full_s;
  assign empty       = empty_s;
  assign count       = count_q;
  assign dout        = dout_s;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_spi_word_fifo.sv
// Self-checking bench for spi_word_fifo: a directed vector table, hand-written
// corner sequences, and a randomized run against a queue-based reference model.
module tb_spi_word_fifo;

  localparam int W     = 32;
  localparam int DEPTH = 16;
  localparam int AFT   = DEPTH - 2;

  logic          axi_clk = 1'b0;
  logic          reset = 1'b0, clear = 1'b0, wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
  logic [W-1:0]  din = '0;
  logic          full, almost_full, empty, overflow, underflow;
  logic [W-1:0]  dout;
  logic [4:0]    count;

  int tests = 0;
  int fails = 0;

  // reference model state
  logic [W-1:0] mq[$];
  logic         m_ovf = 1'b0;
  logic         m_unf = 1'b0;

  spi_word_fifo #(.C_S_AXI_DATA_WIDTH(W), .DEPTH(DEPTH), .ALMOST_FULL_THRESH(AFT)) dut (
    .axi_clk(axi_clk), .reset(reset), .clear(clear), .wr_en(wr_en), .din(din),
    .full(full), .almost_full(almost_full), .rd_en(rd_en), .dout(dout),
    .empty(empty), .count(count), .overflow(overflow), .underflow(underflow),
    .clr_err(clr_err)
  );

  always #5 axi_clk = ~axi_clk;

  typedef struct {
    logic         rst, clr, we, re, ce;
    logic [W-1:0] d;
    logic         e_empty, e_ovf, e_unf;
    int           e_count;
    logic [W-1:0] e_dout;
  } vec_t;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply the FIFO rules to the model for one clock edge.
  task automatic model_step(input logic rst, clr, we, re, ce, input logic [W-1:0] d);
    bit m_empty, m_full, rd_ok, wr_ok;
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      m_empty = (mq.size() == 0);
      m_full  = (mq.size() == DEPTH);
      rd_ok   = re && !m_empty;
      wr_ok   = we && (!m_full || rd_ok);
      if (ce) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
      if (clr) begin
        mq.delete();
      end else begin
        if (rd_ok) void'(mq.pop_front());
        if (wr_ok) mq.push_back(d);
        if (we && !wr_ok) m_ovf = 1'b1;
        if (re && m_empty) m_unf = 1'b1;
      end
    end
  endtask

  task automatic compare_model(input string tag);
    int n;
    logic [W-1:0] hd;
    n  = mq.size();
    hd = (n > 0) ? mq[0] : '0;
    check({tag, ".count"},  W'(count),       W'(n));
    check({tag, ".empty"},  W'(empty),       W'(n == 0));
    check({tag, ".full"},   W'(full),        W'(n == DEPTH));
    check({tag, ".afull"},  W'(almost_full), W'(n >= AFT));
    check({tag, ".dout"},   dout,            hd);
    check({tag, ".ovf"},    W'(overflow),    W'(m_ovf));
    check({tag, ".unf"},    W'(underflow),   W'(m_unf));
  endtask

  // Drive one cycle of inputs, advance the model, then sample after the edge.
  task automatic cyc(input string tag, input logic rst, clr, we, re, ce, input logic [W-1:0] d);
    reset = rst; clear = clr; wr_en = we; rd_en = re; clr_err = ce; din = d;
    model_step(rst, clr, we, re, ce, d);
    @(posedge axi_clk);
    #1;
    reset = 1'b0; clear = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    compare_model(tag);
  endtask

  task automatic idle(input string tag);
    cyc(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  vec_t tbl[13];

  initial begin
    //           rst   clr   we    re    ce    din            empty ovf   unf   cnt dout
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 0, 32'h0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hA5A5_0001, 1'b0, 1'b0, 1'b0, 1, 32'hA5A5_0001};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 0, 32'h0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_1234, 1'b0, 1'b0, 1'b1, 1, 32'h0000_1234};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,         1'b0, 1'b0, 1'b0, 1, 32'h0000_1234};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 0, 32'h0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 0, 32'h0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,         1'b1, 1'b0, 1'b1, 0, 32'h0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,         1'b1, 1'b0, 1'b0, 0, 32'h0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0011, 1'b0, 1'b0, 1'b0, 1, 32'h0000_0011};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0022, 1'b0, 1'b0, 1'b0, 2, 32'h0000_0011};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0033, 1'b1, 1'b0, 1'b0, 0, 32'h0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 0, 32'h0};

    @(negedge axi_clk);

    // ---------------- table vectors ----------------
    for (int i = 0; i < 13; i++) begin
      cyc($sformatf("tbl%0d", i), tbl[i].rst, tbl[i].clr, tbl[i].we, tbl[i].re, tbl[i].ce, tbl[i].d);
      check($sformatf("tbl%0d.t_empty", i), W'(empty),     W'(tbl[i].e_empty));
      check($sformatf("tbl%0d.t_count", i), W'(count),     W'(tbl[i].e_count));
      check($sformatf("tbl%0d.t_dout", i),  dout,          tbl[i].e_dout);
      check($sformatf("tbl%0d.t_ovf", i),   W'(overflow),  W'(tbl[i].e_ovf));
      check($sformatf("tbl%0d.t_unf", i),   W'(underflow), W'(tbl[i].e_unf));
    end

    // ---------------- fill, overflow, drain in order ----------------
    cyc("fill.rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < DEPTH; i++) begin
      cyc("fill", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, W'(i));
      check($sformatf("fill%0d.afull", i), W'(almost_full), W'((i + 1) >= 14));
      check($sformatf("fill%0d.full", i),  W'(full),        W'((i + 1) == 16));
    end
    cyc("ovf", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0099);
    check("ovf.flag",  W'(overflow), 32'd1);
    check("ovf.count", W'(count),    32'd16);
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("drain%0d.data", i), dout, W'(i));
      cyc("drain", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    end
    check("drain.empty", W'(empty), 32'd1);
    cyc("drain.clr_err", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);

    // ---------------- full with simultaneous push+pop ----------------
    for (int i = 0; i < DEPTH; i++) cyc("fp.fill", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h100 + W'(i));
    cyc("fp.both", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF);
    check("fp.count", W'(count),    32'd16);
    check("fp.ovf",   W'(overflow), 32'd0);
    check("fp.dout",  dout,         32'h0000_0101);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) check("fp.last", dout, 32'hDEAD_BEEF);
      cyc("fp.drain", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    end

    // ---------------- wrap-around interleave, then clear ----------------
    cyc("wrap.rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) cyc("wrap.pre", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h200 + W'(i));
    for (int i = 3; i < 20; i++) cyc("wrap.mix", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h200 + W'(i));
    for (int i = 0; i < 3; i++) cyc("wrap.post", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    check("wrap.ovf", W'(overflow),  32'd0);
    check("wrap.unf", W'(underflow), 32'd0);
    cyc("wrap.setunf", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 5; i++) cyc("wrap.five", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h300 + W'(i));
    cyc("wrap.clear", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    check("clear.count", W'(count),     32'd0);
    check("clear.empty", W'(empty),     32'd1);
    check("clear.unf",   W'(underflow), 32'd1);
    check("clear.ovf",   W'(overflow),  32'd0);

    // ---------------- reset mid-transfer ----------------
    for (int i = 0; i < 7; i++) cyc("mid.fill", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h400 + W'(i));
    check("mid.count7", W'(count), 32'd7);
    cyc("mid.rst", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0777);
    check("mid.count", W'(count),     32'd0);
    check("mid.empty", W'(empty),     32'd1);
    check("mid.ovf",   W'(overflow),  32'd0);
    check("mid.unf",   W'(underflow), 32'd0);
    check("mid.dout",  dout,          32'd0);

    // ---------------- randomized run against the model ----------------
    for (int i = 0; i < 4000; i++) begin
      logic r_rst, r_clr, r_we, r_re, r_ce;
      int   wbias;
      wbias = ((i / 150) % 2 == 0) ? 75 : 30;
      r_rst = ($urandom_range(0, 999) == 0);
      r_clr = ($urandom_range(0, 79) == 0);
      r_we  = ($urandom_range(0, 99) < wbias);
      r_re  = ($urandom_range(0, 99) < (100 - wbias));
      r_ce  = ($urandom_range(0, 29) == 0);
      cyc("rnd", r_rst, r_clr, r_we, r_re, r_ce, $urandom());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
